multi_led_ctrl: RTL
===================

MULTI_LED_CTRL -- requirements
Module: multi_led_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- FREQUENCY_IN, 50_000_000, clk frequency in Hz.
- DIGITS, 8, number of multiplexed digits, range 2..16.
- SCAN_HZ, 1000, full-display refresh rate in Hz.
- BLINK_HZ, 2, blink rate in Hz (one on-phase plus one off-phase per period).
- DEAD_CYC, 2, cycles with all digits deselected at each digit switch, range 1..SLOT-1.

REQ-002 The block SHALL derive SLOT = FREQUENCY_IN/(SCAN_HZ*DIGITS) cycles per digit (integer division) and HALF_BLINK = FREQUENCY_IN/(2*BLINK_HZ) cycles; SLOT >= DEAD_CYC+1 is an elaboration-time requirement.

REQ-003 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock.
- rst, in, 1, asynchronous, active-low reset.
- bcd_in, in, 4*DIGITS, hex nibble per digit; digit i is bits [4i+3:4i], digit 0 is rightmost.
- dot_in, in, DIGITS, decimal point per digit.
- blink_in, in, DIGITS, blink enable per digit.
- blank_lz_in, in, 1, leading-zero blanking enable.
- bright_in, in, 4, brightness 0..15.
- update_in, in, 1, single-cycle strobe that loads the input shadow registers.
- seg_cs_out, out, DIGITS, digit select, active-low one-hot; bit i selects digit i.
- seg_data_out, out, 8, {DP,g,f,e,d,c,b,a}, active-high.

Function
REQ-004 On a clk edge with update_in=1, the block SHALL capture bcd_in, dot_in, blink_in, blank_lz_in and bright_in into shadow registers; between strobes, changes on these inputs SHALL have no effect.
REQ-005 The display SHALL switch to newly captured shadow values only at the start of the next digit slot; no slot SHALL show mixed old and new data.
REQ-006 A slot counter SHALL count 0..SLOT-1; on wrap, the digit index SHALL advance i -> i+1, with DIGITS-1 wrapping to 0.
REQ-007 While the slot count is < DEAD_CYC, seg_cs_out SHALL be all ones and seg_data_out SHALL be 0.
REQ-008 The decoder SHALL map nibbles 0-F to standard hex glyphs: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71. DP SHALL be taken from the shadow dot bit.
REQ-009 Leading-zero blanking, when enabled, SHALL blank each digit from DIGITS-1 downward while its nibble is 0 and its dot bit is 0; the first digit failing that test stops blanking. Digit 0 SHALL never be blanked.
REQ-010 A blink-phase flag SHALL toggle every HALF_BLINK cycles, starting in the on-phase; in the off-phase, every digit with its blink bit set SHALL be blanked.
REQ-011 A free-running PWM counter SHALL count 0..14 (wrapping 14 -> 0). The selected digit's cs bit SHALL be asserted only while the PWM count is < bright; bright=0 means the display is dark, and bright=15 means the cs bit is held for the entire non-dead part of the slot.
REQ-012 A blanked digit, or a digit in a PWM-off cycle, SHALL drive seg_cs_out all ones and seg_data_out 0.
REQ-013 Both outputs SHALL be registered, with exactly 1 cycle of latency from the internal counter and index state.
REQ-014 If update_in coincides with a slot boundary, the newly captured values SHALL take effect at the following boundary.

Reset
REQ-015 While rst=0, the block SHALL hold seg_cs_out = all ones, seg_data_out = 0, slot counter = 0, digit index = 0, PWM counter = 0, blink phase = on, and all shadow registers = 0.
REQ-016 Asserting rst mid-slot SHALL take effect immediately and asynchronously. After release, operation SHALL resume from digit 0, slot count 0.

Verification
Bench parameters: FREQUENCY_IN=1600, SCAN_HZ=100, DIGITS=4, BLINK_HZ=50, DEAD_CYC=1. This gives SLOT=4 and HALF_BLINK=16.

REQ-017 Scan order: strobe bcd=0x1234, bright=15, dot=0, blink=0, blank_lz=0 -> seg_cs_out cycles 1110, 1101, 1011, 0111 (each held 3 cycles after a 1-cycle 1111 gap), with seg_data 0x66, 0x4F, 0x5B, 0x06.
REQ-018 Leading zeros: bcd=0x0050, blank_lz=1 -> digits 3 and 2 never selected, digit 1 shows 0x6D, digit 0 shows 0x3F; repeat with dot=4'b1000 -> digit 3 shows 0xBF and digit 2 shows 0x3F.
REQ-019 Blink: blink=4'b0001 -> digit 0 is selected during the first 16 cycles and never selected during the next 16; digits 1-3 are unaffected.
REQ-020 Brightness: bright=0 -> seg_cs_out constantly 1111; bright=7 -> count of cs-asserted cycles over 60 cycles equals the PWM-on/non-dead overlap computed by the reference model.
REQ-021 Update and reset: change bcd_in without a strobe -> no output change. Strobe mid-slot -> new glyph appears only after the next boundary. Pull rst low mid-slot -> outputs go to 1111/0x00 the same cycle; after release, digit 0 is the first selected.

Source files
------------

// File: rtl/multi_led_ctrl.sv
// Multiplexed seven-segment display controller: shadowed inputs, per-digit scan
// with dead time, leading-zero blanking, per-digit blink and PWM brightness.
module multi_led_ctrl #(
    parameter int unsigned FREQUENCY_IN = 50_000_000,
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SCAN_HZ      = 1000,
    parameter int unsigned BLINK_HZ     = 2,
    parameter int unsigned DEAD_CYC     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dot_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  blank_lz_in,
    input  logic [3:0]            bright_in,
    input  logic                  update_in,
    output logic [DIGITS-1:0]     seg_cs_out,
    output logic [7:0]            seg_data_out
);

    localparam int unsigned SLOT       = FREQUENCY_IN / (SCAN_HZ * DIGITS);
    localparam int unsigned HALF_BLINK = FREQUENCY_IN / (2 * BLINK_HZ);
    localparam int unsigned SW         = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned DW         = $clog2(DIGITS);
    localparam int unsigned BW         = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;

    if (SLOT < DEAD_CYC + 1) begin : g_slot_check
        $error("multi_led_ctrl: SLOT must be at least DEAD_CYC+1");
    end
    if (DIGITS < 2 || DIGITS > 16) begin : g_digits_check
        $error("multi_led_ctrl: DIGITS must be in 2..16");
    end

    logic [4*DIGITS-1:0] sh_bcd_q, ds_bcd_q;
    logic [DIGITS-1:0]   sh_dot_q, ds_dot_q;
    logic [DIGITS-1:0]   sh_blink_q, ds_blink_q;
    logic                sh_lz_q, ds_lz_q;
    logic [3:0]          sh_bright_q, ds_bright_q;

    logic [SW-1:0]       slot_q, slot_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [3:0]          pwm_q, pwm_d;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic                blink_on_q, blink_on_d;
    logic                slot_wrap;

    logic [DIGITS-1:0]   cs_q, cs_d;
    logic [7:0]          data_q, data_d;
    logic [DIGITS-1:0]   lz_blank;
    logic [3:0]          nib;
    logic                show;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        slot_wrap  = (slot_q == SW'(SLOT - 1));
        slot_d     = slot_wrap ? '0 : slot_q + 1'b1;
        dig_d      = dig_q;
        if (slot_wrap) begin
            dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
        end
        pwm_d      = (pwm_q == 4'd14) ? '0 : pwm_q + 1'b1;
        bcnt_d     = bcnt_q + 1'b1;
        blink_on_d = blink_on_q;
        if (bcnt_q == BW'(HALF_BLINK - 1)) begin
            bcnt_d     = '0;
            blink_on_d = ~blink_on_q;
        end
    end

    // Blanking runs from the top digit down and stops at the first significant one.
    always_comb begin
        logic run;
        lz_blank = '0;
        run      = ds_lz_q;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            if (run && ds_bcd_q[4*i +: 4] == 4'h0 && !ds_dot_q[i]) begin
                lz_blank[i] = 1'b1;
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        nib    = ds_bcd_q[{dig_q, 2'b00} +: 4];
        show   = (slot_q >= SW'(DEAD_CYC))
               && !lz_blank[dig_q]
               && !(!blink_on_q && ds_blink_q[dig_q])
               && (pwm_q < ds_bright_q);
        cs_d   = '1;
        data_d = '0;
        if (show) begin
            cs_d[dig_q] = 1'b0;
            data_d      = {ds_dot_q[dig_q], glyph(nib)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_bcd_q    <= '0;
            sh_dot_q    <= '0;
            sh_blink_q  <= '0;
            sh_lz_q     <= 1'b0;
            sh_bright_q <= '0;
            ds_bcd_q    <= '0;
            ds_dot_q    <= '0;
            ds_blink_q  <= '0;
            ds_lz_q     <= 1'b0;
            ds_bright_q <= '0;
            slot_q      <= '0;
            dig_q       <= '0;
            pwm_q       <= '0;
            bcnt_q      <= '0;
            blink_on_q  <= 1'b1;
            cs_q        <= '1;
            data_q      <= '0;
        end else begin
            if (update_in) begin
                sh_bcd_q    <= bcd_in;
                sh_dot_q    <= dot_in;
                sh_blink_q  <= blink_in;
                sh_lz_q     <= blank_lz_in;
                sh_bright_q <= bright_in;
            end
            // Display copy takes the pre-edge shadow, so a strobe on a boundary waits one slot.
            if (slot_wrap) begin
                ds_bcd_q    <= sh_bcd_q;
                ds_dot_q    <= sh_dot_q;
                ds_blink_q  <= sh_blink_q;
                ds_lz_q     <= sh_lz_q;
                ds_bright_q <= sh_bright_q;
            end
            slot_q     <= slot_d;
            dig_q      <= dig_d;
            pwm_q      <= pwm_d;
            bcnt_q     <= bcnt_d;
            blink_on_q <= blink_on_d;
            cs_q       <= cs_d;
            data_q     <= data_d;
        end
    end

    assign seg_cs_out   = cs_q;
    assign seg_data_out = data_q;

endmodule
